// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Receiving end of the three-wire serial link (en, sda, scl). Frames are
//   sampled on synchronized scl rising edges, assembled MSB first into
//   DATA_WIDTH-bit words and buffered in a show-ahead FIFO.
//
//   Optional feature macro: RX_PARITY_EN
//     defined   : each frame carries one extra even-parity bit after the data LSB
//     undefined : frames are exactly DATA_WIDTH bits, status_o[5] tied 0
//
//   Ports
//     clk_i     in   system clock (rising edge)
//     reset_i   in   asynchronous active-high reset
//     en_i      in   link frame enable (asynchronous)
//     sda_i     in   link serial data (asynchronous)
//     scl_i     in   link serial clock (asynchronous)
//     rd_i      in   pop FIFO head (single-cycle pulse)
//     clr_i     in   clear sticky error bits (single-cycle pulse)
//     data_o    out  FIFO head word, 0 when empty
//     stb_o     out  one-cycle pulse per pushed word
//     status_o  out  {2'b0, parity err, busy, frame err, overflow, full, not empty}
module serial_frame_receiver #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic                  sda_i,
  input  logic                  scl_i,
  input  logic                  rd_i,
  input  logic                  clr_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  stb_o,
  output logic [7:0]            status_o
);

`ifdef RX_PARITY_EN
  localparam int unsigned EXP_BITS = DATA_WIDTH + 1;
`else
  localparam int unsigned EXP_BITS = DATA_WIDTH;
`endif
  localparam int unsigned SR_W    = EXP_BITS;
  localparam int unsigned CNT_MAX = EXP_BITS + 1;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned PW      = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Link synchronizers and edge-history registers
  logic r_en_meta, r_en_sync, r_en_prev;
  logic r_sda_meta, r_sda_sync;
  logic r_scl_meta, r_scl_sync, r_scl_prev;

  // Frame FSM state
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SR_W-1:0]  r_shift;
  logic             r_busy;
  logic             r_ovf;
  logic             r_ferr;
  logic             w_perr_bit;

  // FIFO state
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic                  r_nempty;
  logic                  r_full;
  logic                  r_stb;
  logic [DATA_WIDTH-1:0] r_data;

  // Combinational helpers
  logic                  w_en_rise, w_en_fall, w_scl_rise;
  logic                  w_cnt_ok, w_par_ok, w_frame_ok;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_pop, w_push;
  logic [PW-1:0]         w_wr_ptr_n, w_rd_ptr_n;
  logic [DATA_WIDTH-1:0] w_head_n;
  logic                  w_empty_n, w_full_n;

  // Two-flop synchronizers plus one history flop for edge detection
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_en_meta  <= 1'b0;
      r_en_sync  <= 1'b0;
      r_en_prev  <= 1'b0;
      r_sda_meta <= 1'b0;
      r_sda_sync <= 1'b0;
      r_scl_meta <= 1'b0;
      r_scl_sync <= 1'b0;
      r_scl_prev <= 1'b0;
    end else begin
      r_en_meta  <= en_i;
      r_en_sync  <= r_en_meta;
      r_en_prev  <= r_en_sync;
      r_sda_meta <= sda_i;
      r_sda_sync <= r_sda_meta;
      r_scl_meta <= scl_i;
      r_scl_sync <= r_scl_meta;
      r_scl_prev <= r_scl_sync;
    end
  end

  // Frame validation and FIFO next-state
  always_comb begin
    w_en_rise  = r_en_sync & ~r_en_prev;
    w_en_fall  = ~r_en_sync & r_en_prev;
    w_scl_rise = r_scl_sync & ~r_scl_prev;
    w_cnt_ok   = (r_cnt == CNT_W'(EXP_BITS));
`ifdef RX_PARITY_EN
    w_word     = r_shift[SR_W-1:1];
    w_par_ok   = ~(^r_shift);
`else
    w_word     = r_shift;
    w_par_ok   = 1'b1;
`endif
    w_frame_ok = (r_state == S_DONE) && w_cnt_ok && w_par_ok;
    w_pop      = rd_i && r_nempty;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
    w_push     = w_frame_ok && (!r_full || w_pop);
    w_wr_ptr_n = r_wr_ptr + PW'(w_push);
    w_rd_ptr_n = r_rd_ptr + PW'(w_pop);
    // Bypass the word being written when it becomes the new head
    if (w_push && (w_rd_ptr_n == r_wr_ptr)) begin
      w_head_n = w_word;
    end else begin
      w_head_n = r_mem[w_rd_ptr_n[AW-1:0]];
    end
    w_empty_n = (w_rd_ptr_n == w_wr_ptr_n);
    w_full_n  = (w_rd_ptr_n[AW-1:0] == w_wr_ptr_n[AW-1:0]) &&
                (w_rd_ptr_n[AW] != w_wr_ptr_n[AW]);
  end

  // Frame FSM with sticky error bits; error events override a same-cycle clear
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (clr_i) begin
        r_ovf  <= 1'b0;
        r_ferr <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          r_cnt   <= '0;
          r_shift <= '0;
          if (w_en_rise) begin
            r_state <= S_RECV;
            r_busy  <= 1'b1;
          end
        end
        S_RECV: begin
          if (w_scl_rise) begin
            r_shift <= {r_shift[SR_W-2:0], r_sda_sync};
            if (r_cnt != CNT_W'(CNT_MAX)) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          if (w_en_fall) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
          end
        end
        S_DONE: begin
          if (!w_cnt_ok) begin
            r_ferr <= 1'b1;
          end else if (w_par_ok && !w_push) begin
            r_ovf <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RX_PARITY_EN
  logic r_perr;

  // Sticky parity error, set on a correctly sized frame with bad parity
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_perr <= 1'b0;
    end else begin
      if (clr_i) begin
        r_perr <= 1'b0;
      end
      if ((r_state == S_DONE) && w_cnt_ok && !w_par_ok) begin
        r_perr <= 1'b1;
      end
    end
  end

  assign w_perr_bit = r_perr;
`else
  assign w_perr_bit = 1'b0;
`endif

  // FIFO storage, pointers and registered show-ahead head
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_nempty <= 1'b0;
      r_full   <= 1'b0;
      r_stb    <= 1'b0;
      r_data   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= w_word;
      end
      r_wr_ptr <= w_wr_ptr_n;
      r_rd_ptr <= w_rd_ptr_n;
      r_nempty <= ~w_empty_n;
      r_full   <= w_full_n;
      r_stb    <= w_push;
      r_data   <= w_empty_n ? '0 : w_head_n;
    end
  end

  assign data_o   = r_data;
  assign stb_o    = r_stb;
  assign status_o = {2'b00, w_perr_bit, r_busy, r_ferr, r_ovf, r_full, r_nempty};

endmodule
